if_id_skid_reg: RTL

Parametrised successor to the fixed IF/ID pipeline register. Carries instruction, PC and PC+4 from Fetch to Decode using a valid/ready handshake instead of a bare enable. Contains a 2-entry skid (main + skid slot), so Fetch sees a registered ready and never loses an instruction when Decode stalls. Sits between the fetch unit and the decode stage (register file / immediate extender).

---
 rtl/riscv_pipe_pkg.sv | 26 ++
 rtl/pipe_skid_slot.sv | 70 +++++++
 rtl/if_id_skid_reg.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/riscv_pipe_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pipe_pkg
// Shared definitions for the RISC-V pipeline registers.
//   XLEN_DEF / ILEN_DEF : default data-path and instruction widths
//   NOP_INSTR_DEF       : canonical bubble instruction (addi x0,x0,0)
//   if_id_payload_t     : Fetch->Decode payload at default widths
//   payload_width()     : packed width of {instr, pc, pcplus4}
// -----------------------------------------------------------------------------
package riscv_pipe_pkg;

    localparam int          XLEN_DEF      = 32;
    localparam int          ILEN_DEF      = 32;
    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;

    typedef struct packed {
        logic [ILEN_DEF-1:0] instr;
        logic [XLEN_DEF-1:0] pc;
        logic [XLEN_DEF-1:0] pcplus4;
    } if_id_payload_t;

    // Packed width of one payload for arbitrary widths.
    function automatic int payload_width(input int xlen, input int ilen);
        return ilen + 2 * xlen;
    endfunction

endpackage

// File: rtl/pipe_skid_slot.sv
// -----------------------------------------------------------------------------
// pipe_skid_slot
// One payload register with a valid bit. Used twice inside if_id_skid_reg
// (main slot driving Decode, skid slot absorbing one stalled instruction).
// Priority: reset > clr_i > load_i > drop_i > hold.
// Ports:
//   clk       rising-edge clock
//   reset     synchronous active-low reset (valid=0, data=CLR_VAL)
//   clr_i     flush: valid=0, data=CLR_VAL
//   load_i    capture data_i, valid=1
//   drop_i    valid=0, data <- bubble_i (caller decides what a bubble looks like)
//   data_i    payload to load
//   bubble_i  payload to hold while empty after a drop
//   valid_o   slot holds a live payload
//   data_o    stored payload
// -----------------------------------------------------------------------------
module pipe_skid_slot
    import riscv_pipe_pkg::*;
#(
    parameter int           W       = payload_width(XLEN_DEF, ILEN_DEF),
    parameter logic [W-1:0] CLR_VAL = {W{1'b0}}
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic         drop_i,
    input  logic [W-1:0] data_i,
    input  logic [W-1:0] bubble_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q,  data_d;

    // Next-state selection for the slot.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (clr_i) begin
            valid_d = 1'b0;
            data_d  = CLR_VAL;
        end else if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (drop_i) begin
            valid_d = 1'b0;
            data_d  = bubble_i;
        end else begin
            valid_d = valid_q;
            data_d  = data_q;
        end
    end

    // Slot state flops with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q <= 1'b0;
            data_q  <= CLR_VAL;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/if_id_skid_reg.sv
// -----------------------------------------------------------------------------
// if_id_skid_reg
// IF/ID pipeline register with valid/ready handshake and a two-entry skid
// (main + skid slot). readyF is a flop driven only by skid occupancy, and all
// D-side outputs come straight from the main slot flops.
// Ports:
//   clk, reset (sync, active-low), clr (flush, active-high)
//   validF/readyF, InstrF, PCF, PCplus4F        : Fetch side
//   validD/readyD, InstrD, PCD, PCplus4D        : Decode side
// Optional build macro IFID_PERF_CNT_EN adds:
//   stall_cnt : cycles with validD=1 & readyD=0 (saturating)
//   flush_cnt : cycles with clr=1 (saturating)
// -----------------------------------------------------------------------------
module if_id_skid_reg
    import riscv_pipe_pkg::*;
#(
    parameter int              XLEN      = XLEN_DEF,
    parameter int              ILEN      = ILEN_DEF,
    parameter logic [ILEN-1:0] NOP_INSTR = NOP_INSTR_DEF[ILEN-1:0]
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clr,
    input  logic            validF,
    output logic            readyF,
    input  logic [ILEN-1:0] InstrF,
    input  logic [XLEN-1:0] PCF,
    input  logic [XLEN-1:0] PCplus4F,
    output logic            validD,
    input  logic            readyD,
    output logic [ILEN-1:0] InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCplus4D
`ifdef IFID_PERF_CNT_EN
    ,
    output logic [31:0]     stall_cnt,
    output logic [31:0]     flush_cnt
`endif
);

    localparam int           PW      = payload_width(XLEN, ILEN);
    localparam logic [PW-1:0] CLR_VAL = {NOP_INSTR, {(2*XLEN){1'b0}}};

    logic          main_valid_s, skid_valid_s;
    logic [PW-1:0] main_data_s,  skid_data_s;
    logic [PW-1:0] f_data_s, main_in_s, main_bubble_s;
    logic          fire_f_s, fire_d_s;
    logic          main_load_s, main_drop_s, main_from_skid_s;
    logic          skid_load_s, skid_drop_s, skid_valid_next_s;
    logic          ready_q, ready_d;

    assign f_data_s      = {InstrF, PCF, PCplus4F};
    assign fire_f_s      = validF & ready_q;
    assign fire_d_s      = main_valid_s & readyD;
    assign main_in_s     = main_from_skid_s ? skid_data_s : f_data_s;
    // A drained main slot shows NOP but keeps the last PC/PC+4.
    assign main_bubble_s = {NOP_INSTR, main_data_s[2*XLEN-1:0]};

    // Slot control: decide which slot loads, drains or refills this cycle.
    always_comb begin
        main_load_s      = 1'b0;
        main_drop_s      = 1'b0;
        main_from_skid_s = 1'b0;
        skid_load_s      = 1'b0;
        skid_drop_s      = 1'b0;
        if (clr) begin
            // Slots clear themselves; a coincident F transfer is discarded.
            main_load_s = 1'b0;
        end else if (skid_valid_s) begin
            // readyF is low here, so only Decode can move things.
            if (fire_d_s) begin
                main_load_s      = 1'b1;
                main_from_skid_s = 1'b1;
                skid_drop_s      = 1'b1;
            end else begin
                main_load_s = 1'b0;
            end
        end else if (fire_f_s) begin
            if (!main_valid_s || fire_d_s) begin
                main_load_s = 1'b1;
            end else begin
                skid_load_s = 1'b1;
            end
        end else if (fire_d_s) begin
            main_drop_s = 1'b1;
        end else begin
            main_load_s = 1'b0;
        end
    end

    // readyF tracks the skid occupancy that the slots will hold next cycle.
    always_comb begin
        if (clr) begin
            skid_valid_next_s = 1'b0;
        end else if (skid_load_s) begin
            skid_valid_next_s = 1'b1;
        end else if (skid_drop_s) begin
            skid_valid_next_s = 1'b0;
        end else begin
            skid_valid_next_s = skid_valid_s;
        end
        ready_d = ~skid_valid_next_s;
    end

    // Registered ready; held low during reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= ready_d;
        end
    end

    pipe_skid_slot #(
        .W       (PW),
        .CLR_VAL (CLR_VAL)
    ) u_main (
        .clk      (clk),
        .reset    (reset),
        .clr_i    (clr),
        .load_i   (main_load_s),
        .drop_i   (main_drop_s),
        .data_i   (main_in_s),
        .bubble_i (main_bubble_s),
        .valid_o  (main_valid_s),
        .data_o   (main_data_s)
    );

    pipe_skid_slot #(
        .W       (PW),
        .CLR_VAL (CLR_VAL)
    ) u_skid (
        .clk      (clk),
        .reset    (reset),
        .clr_i    (clr),
        .load_i   (skid_load_s),
        .drop_i   (skid_drop_s),
        .data_i   (f_data_s),
        .bubble_i (skid_data_s),
        .valid_o  (skid_valid_s),
        .data_o   (skid_data_s)
    );

    assign readyF   = ready_q;
    assign validD   = main_valid_s;
    assign InstrD   = main_data_s[PW-1 -: ILEN];
    assign PCD      = main_data_s[2*XLEN-1 -: XLEN];
    assign PCplus4D = main_data_s[XLEN-1:0];

`ifdef IFID_PERF_CNT_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    // Saturating stall and flush event counters.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt_q <= 32'h0000_0000;
            flush_cnt_q <= 32'h0000_0000;
        end else begin
            if (main_valid_s && !readyD && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'h0000_0001;
            end else begin
                stall_cnt_q <= stall_cnt_q;
            end
            if (clr && (flush_cnt_q != 32'hFFFF_FFFF)) begin
                flush_cnt_q <= flush_cnt_q + 32'h0000_0001;
            end else begin
                flush_cnt_q <= flush_cnt_q;
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule
